// File: rtl/fetch_pkg.sv
// Shared types and constants for the front-end fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        single;
    logic        btb_hit;
    logic [31:0] btb_target;
    logic        btb_taken;
  } fetch_req_t;

  localparam logic [31:0] INST_BYTES = 32'd4;

  // Advance a PC by a number of instruction slots, wrapping mod 2^32.
  function automatic logic [31:0] pc_step(input logic [31:0] pc, input logic [1:0] slots);
    logic [31:0] step;
    step = (slots == 2'd2) ? (INST_BYTES << 1) : INST_BYTES;
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem request at a time and
// enqueues single or dual instruction words into the iq.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        imem_dual,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata1,
  input  logic [31:0] imem_rdata2,
  input  logic        btb_hit,
  input  logic [31:0] btb_target,
  input  logic        btb_taken,
  input  logic        iq_full,
  input  logic        mispredict,
  input  logic [31:0] redirect_pc,
  input  logic        singlemode,
  output logic        inst1_in_valid,
  output logic        inst2_in_valid,
  output logic [31:0] inst1_in,
  output logic [31:0] inst2_in,
  output logic [31:0] inst1_in_pc4,
  output logic [31:0] inst2_in_pc4,
  output logic        in_branch_valid,
  output logic [31:0] in_btb_pc_predict,
  output logic        in_direct_predict,
  output logic        err_timeout
);

  localparam int CW = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(FETCH_TIMEOUT - 1);

  fetch_state_e  state_r;
  fetch_req_t    req_r;
  logic [31:0]   pc_r;
  logic          drop_r;
  logic [CW-1:0] cnt_r;

  logic          single_s;
  logic [31:0]   next_pc_s;

  // Width and next-PC decision for a request issued from the current PC.
  always_comb begin
    single_s  = singlemode | btb_hit | pc_r[2];
    next_pc_s = pc_step(pc_r, 2'd2);
    if (single_s) begin
      if (btb_hit && btb_taken) begin
        next_pc_s = btb_target;
      end else begin
        next_pc_s = pc_step(pc_r, 2'd1);
      end
    end else begin
      next_pc_s = pc_step(pc_r, 2'd2);
    end
  end

  // Sequencer state, request latch and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r           <= IDLE;
      pc_r              <= RESET_PC;
      drop_r            <= 1'b0;
      cnt_r             <= '0;
      req_r             <= '0;
      imem_req          <= 1'b0;
      imem_addr         <= 32'h0000_0000;
      imem_dual         <= 1'b0;
      inst1_in_valid    <= 1'b0;
      inst2_in_valid    <= 1'b0;
      inst1_in          <= 32'h0000_0000;
      inst2_in          <= 32'h0000_0000;
      inst1_in_pc4      <= 32'h0000_0000;
      inst2_in_pc4      <= 32'h0000_0000;
      in_branch_valid   <= 1'b0;
      in_btb_pc_predict <= 32'h0000_0000;
      in_direct_predict <= 1'b0;
      err_timeout       <= 1'b0;
    end else begin
      imem_req          <= 1'b0;
      inst1_in_valid    <= 1'b0;
      inst2_in_valid    <= 1'b0;
      in_branch_valid   <= 1'b0;
      in_direct_predict <= 1'b0;
      err_timeout       <= 1'b0;

      if (mispredict) begin
        // Redirect wins over everything; never issue in this cycle.
        pc_r <= redirect_pc;
        case (state_r)
          WAIT: begin
            if (imem_rvalid) begin
              drop_r  <= 1'b0;
              cnt_r   <= '0;
              state_r <= ISSUE;
            end else begin
              drop_r  <= 1'b1;
              cnt_r   <= (cnt_r >= CNT_LIMIT) ? cnt_r : cnt_r + 1'b1;
              state_r <= WAIT;
            end
          end
          ISSUE: begin
            drop_r  <= (drop_r && imem_rvalid) ? 1'b0 : drop_r;
            cnt_r   <= '0;
            state_r <= ISSUE;
          end
          default: begin
            cnt_r   <= '0;
            state_r <= ISSUE;
          end
        endcase
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= ISSUE;
          end
          ISSUE: begin
            // A timed-out request is still outstanding until its late response drains.
            if (drop_r) begin
              drop_r <= imem_rvalid ? 1'b0 : 1'b1;
            end else if (!iq_full) begin
              imem_req  <= 1'b1;
              imem_addr <= pc_r;
              imem_dual <= ~single_s;
              req_r     <= '{pc: pc_r, single: single_s, btb_hit: btb_hit,
                             btb_target: btb_target, btb_taken: btb_taken};
              pc_r      <= next_pc_s;
              cnt_r     <= '0;
              state_r   <= WAIT;
            end else begin
              state_r <= ISSUE;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              cnt_r   <= '0;
              state_r <= ISSUE;
              if (drop_r) begin
                drop_r <= 1'b0;
              end else begin
                inst1_in_valid <= 1'b1;
                inst1_in       <= imem_rdata1;
                inst1_in_pc4   <= pc_step(req_r.pc, 2'd1);
                if (req_r.single) begin
                  inst2_in_valid    <= 1'b0;
                  in_branch_valid   <= req_r.btb_hit;
                  in_btb_pc_predict <= req_r.btb_target;
                  in_direct_predict <= req_r.btb_taken;
                end else begin
                  inst2_in_valid <= 1'b1;
                  inst2_in       <= imem_rdata2;
                  inst2_in_pc4   <= pc_step(req_r.pc, 2'd2);
                end
              end
            end else if (cnt_r >= CNT_LIMIT) begin
              // Re-fetch the lost request unless it had already been redirected away.
              err_timeout <= 1'b1;
              drop_r      <= 1'b1;
              cnt_r       <= '0;
              state_r     <= ISSUE;
              pc_r        <= drop_r ? pc_r : req_r.pc;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with hand-computed expected values.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_dual;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata1 = 32'h0;
  logic [31:0] imem_rdata2 = 32'h0;
  logic        btb_hit = 1'b0;
  logic [31:0] btb_target = 32'h0;
  logic        btb_taken = 1'b0;
  logic        iq_full = 1'b0;
  logic        mispredict = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        singlemode = 1'b0;
  logic        inst1_in_valid, inst2_in_valid;
  logic [31:0] inst1_in, inst2_in, inst1_in_pc4, inst2_in_pc4;
  logic        in_branch_valid;
  logic [31:0] in_btb_pc_predict;
  logic        in_direct_predict;
  logic        err_timeout;

  int n_vec = 0;
  int n_miss = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0100), .FETCH_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_dual(imem_dual),
    .imem_rvalid(imem_rvalid), .imem_rdata1(imem_rdata1), .imem_rdata2(imem_rdata2),
    .btb_hit(btb_hit), .btb_target(btb_target), .btb_taken(btb_taken),
    .iq_full(iq_full), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .singlemode(singlemode),
    .inst1_in_valid(inst1_in_valid), .inst2_in_valid(inst2_in_valid),
    .inst1_in(inst1_in), .inst2_in(inst2_in),
    .inst1_in_pc4(inst1_in_pc4), .inst2_in_pc4(inst2_in_pc4),
    .in_branch_valid(in_branch_valid), .in_btb_pc_predict(in_btb_pc_predict),
    .in_direct_predict(in_direct_predict), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a request strobe, then check address and width.
  task automatic wait_req(input logic [31:0] addr, input logic dual);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req) break;
    end
    check_vec("req_seen", 32'(imem_req), 32'd1);
    check_vec("req_addr", imem_addr, addr);
    check_vec("req_dual", 32'(imem_dual), 32'(dual));
  endtask

  // Called at the negedge where the request is visible; leaves the bench at the enqueue negedge.
  task automatic respond(input int lat, input logic [31:0] d1, input logic [31:0] d2);
    repeat (lat) @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata1 = d1;
    imem_rdata2 = d2;
    @(negedge clk);
    imem_rvalid = 1'b0;
  endtask

  task automatic check_dual(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] pc);
    check_vec("dual_v1", 32'(inst1_in_valid), 32'd1);
    check_vec("dual_v2", 32'(inst2_in_valid), 32'd1);
    check_vec("dual_i1", inst1_in, d1);
    check_vec("dual_i2", inst2_in, d2);
    check_vec("dual_pc4_1", inst1_in_pc4, pc + 32'd4);
    check_vec("dual_pc4_2", inst2_in_pc4, pc + 32'd8);
    check_vec("dual_bv", 32'(in_branch_valid), 32'd0);
  endtask

  task automatic check_single(input logic [31:0] d1, input logic [31:0] pc4, input logic bv,
                              input logic [31:0] tgt, input logic dir);
    check_vec("sgl_v1", 32'(inst1_in_valid), 32'd1);
    check_vec("sgl_v2", 32'(inst2_in_valid), 32'd0);
    check_vec("sgl_i1", inst1_in, d1);
    check_vec("sgl_pc4", inst1_in_pc4, pc4);
    check_vec("sgl_bv", 32'(in_branch_valid), 32'(bv));
    if (bv) begin
      check_vec("sgl_tgt", in_btb_pc_predict, tgt);
      check_vec("sgl_dir", 32'(in_direct_predict), 32'(dir));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check_vec("rst_req", 32'(imem_req), 32'd0);
    check_vec("rst_addr", imem_addr, 32'd0);
    check_vec("rst_dual", 32'(imem_dual), 32'd0);
    check_vec("rst_v1", 32'(inst1_in_valid), 32'd0);
    check_vec("rst_err", 32'(err_timeout), 32'd0);
    rst = 1'b1;

    // Sequential dual fetches from RESET_PC
    wait_req(32'h100, 1'b1);
    respond(1, 32'hA000_0001, 32'hA000_0002);
    check_dual(32'hA000_0001, 32'hA000_0002, 32'h100);
    wait_req(32'h108, 1'b1);
    respond(1, 32'hA000_0003, 32'hA000_0004);
    check_dual(32'hA000_0003, 32'hA000_0004, 32'h108);

    // Backpressure: response still enqueued, no request while full
    wait_req(32'h110, 1'b1);
    iq_full = 1'b1;
    respond(1, 32'hA000_0005, 32'hA000_0006);
    check_dual(32'hA000_0005, 32'hA000_0006, 32'h110);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_vec("full_noreq", 32'(imem_req), 32'd0);
    end
    iq_full = 1'b0;
    @(negedge clk);
    check_vec("full_release_req", 32'(imem_req), 32'd1);
    check_vec("full_release_addr", imem_addr, 32'h118);
    respond(1, 32'hA000_0007, 32'hA000_0008);
    check_dual(32'hA000_0007, 32'hA000_0008, 32'h118);

    // Redirect to 0x200 with a taken BTB hit there
    mispredict = 1'b1;
    redirect_pc = 32'h200;
    btb_hit = 1'b1;
    btb_target = 32'h400;
    btb_taken = 1'b1;
    @(negedge clk);
    mispredict = 1'b0;
    check_vec("mp_noreq", 32'(imem_req), 32'd0);
    check_vec("mp_nov1", 32'(inst1_in_valid), 32'd0);
    wait_req(32'h200, 1'b0);
    btb_hit = 1'b0;
    btb_target = 32'h0;
    btb_taken = 1'b0;
    respond(1, 32'hB000_0001, 32'hDEAD_BEEF);
    check_single(32'hB000_0001, 32'h204, 1'b1, 32'h400, 1'b1);

    // Mispredict while a 4-cycle response is outstanding
    wait_req(32'h400, 1'b1);
    @(negedge clk);
    @(negedge clk);
    mispredict = 1'b1;
    redirect_pc = 32'h800;
    @(negedge clk);
    mispredict = 1'b0;
    check_vec("drop_noreq0", 32'(imem_req), 32'd0);
    check_vec("drop_nov0", 32'(inst1_in_valid), 32'd0);
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata1 = 32'hBAD0_0001;
    imem_rdata2 = 32'hBAD0_0002;
    check_vec("drop_noreq1", 32'(imem_req), 32'd0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    check_vec("drop_nov1", 32'(inst1_in_valid), 32'd0);
    check_vec("drop_nov2", 32'(inst2_in_valid), 32'd0);
    check_vec("drop_noreq2", 32'(imem_req), 32'd0);
    @(negedge clk);
    check_vec("redir_req", 32'(imem_req), 32'd1);
    check_vec("redir_addr", imem_addr, 32'h800);
    respond(2, 32'hC000_0001, 32'hC000_0002);
    check_dual(32'hC000_0001, 32'hC000_0002, 32'h800);

    // Mispredict coincident with the response
    wait_req(32'h808, 1'b1);
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata1 = 32'hBAD0_0003;
    mispredict = 1'b1;
    redirect_pc = 32'hA00;
    @(negedge clk);
    imem_rvalid = 1'b0;
    mispredict = 1'b0;
    check_vec("coin_nov1", 32'(inst1_in_valid), 32'd0);
    check_vec("coin_nov2", 32'(inst2_in_valid), 32'd0);

    // Timeout: no response, then a late response that must be discarded
    wait_req(32'hA00, 1'b1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check_vec("to_noerr", 32'(err_timeout), 32'd0);
      check_vec("to_noreq", 32'(imem_req), 32'd0);
    end
    @(negedge clk);
    check_vec("to_err", 32'(err_timeout), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_vec("to_errpulse", 32'(err_timeout), 32'd0);
      check_vec("to_hold", 32'(imem_req), 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata1 = 32'hBAD0_0004;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check_vec("late_nov1", 32'(inst1_in_valid), 32'd0);
    wait_req(32'hA00, 1'b1);
    respond(1, 32'hD000_0001, 32'hD000_0002);
    check_dual(32'hD000_0001, 32'hD000_0002, 32'hA00);

    // PC wrap through the top of the address space
    mispredict = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    mispredict = 1'b0;
    wait_req(32'hFFFF_FFF8, 1'b1);
    respond(1, 32'hE000_0001, 32'hE000_0002);
    check_dual(32'hE000_0001, 32'hE000_0002, 32'hFFFF_FFF8);
    check_vec("wrap_pc4_2", inst2_in_pc4, 32'h0000_0000);

    // singlemode forces single width at the next issue
    singlemode = 1'b1;
    wait_req(32'h0, 1'b0);
    singlemode = 1'b0;
    respond(1, 32'hF000_0001, 32'hF000_0002);
    check_single(32'hF000_0001, 32'h4, 1'b0, 32'h0, 1'b0);
    wait_req(32'h4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
